// File: rtl/ps2_space_decoder.sv
// PS/2 device-to-host receiver with spacebar make/break decoding.
// Filters ps2c, deframes 11-bit frames, and emits a one-cycle strobe per fresh spacebar press.
module ps2_space_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic       spacebar_pressed,
   output logic       space_held,
   output logic [7:0] led,
   output logic       frame_err
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

   logic                  ps2c_s1, ps2c_s2;
   logic                  ps2d_s1, ps2d_s2;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  clk_f;
   logic                  fall;

   state_e                state;
   logic [2:0]            bit_cnt;
   logic [7:0]            shreg;
   logic                  parity;
   logic [CNT_W-1:0]      wd_cnt;
   logic                  byte_valid;

   logic                  brk;
   logic                  ext;
   logic [6:0]            led_low;

   // Synchronizers and filter idle high so reset looks like an inactive bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps2c_s1 <= 1'b1;
         ps2c_s2 <= 1'b1;
         ps2d_s1 <= 1'b1;
         ps2d_s2 <= 1'b1;
         filt_sr <= '1;
         clk_f   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous-cycle value of its neighbour.
         ps2c_s1 <= ps2c;
         ps2c_s2 <= ps2c_s1;
         ps2d_s1 <= ps2d;
         ps2d_s2 <= ps2d_s1;
         filt_sr <= {filt_sr[FILTER_LEN-2:0], ps2c_s2};
         if (&filt_sr)
            clk_f <= 1'b1;
         else if (~|filt_sr)
            clk_f <= 1'b0;
      end
   end

   assign fall = clk_f & ~|filt_sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         parity     <= 1'b0;
         wd_cnt     <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (fall)
            wd_cnt <= '0;
         else if (state != IDLE)
            wd_cnt <= wd_cnt + 1'b1;

         if (state != IDLE && !fall && wd_cnt == CNT_LAST) begin
            // A stalled frame is abandoned; the partial byte is never presented.
            state     <= IDLE;
            frame_err <= 1'b1;
            wd_cnt    <= '0;
            shreg     <= '0;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (!ps2d_s2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               DATA: begin
                  shreg   <= {ps2d_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= PARITY;
               end
               PARITY: begin
                  parity <= ps2d_s2;
                  state  <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (ps2d_s2 && (^shreg ^ parity))
                     byte_valid <= 1'b1;
                  else
                     frame_err <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Scan-code decoder; shreg stays stable for the cycle after the stop bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         brk              <= 1'b0;
         ext              <= 1'b0;
         space_held       <= 1'b0;
         led_low          <= '0;
         spacebar_pressed <= 1'b0;
      end else begin
         spacebar_pressed <= 1'b0;
         if (byte_valid) begin
            led_low <= shreg[6:0];
            if (shreg == 8'hF0) begin
               brk <= 1'b1;
            end else if (shreg == 8'hE0) begin
               ext <= 1'b1;
            end else begin
               if (shreg == 8'h29 && !ext) begin
                  if (brk) begin
                     space_held <= 1'b0;
                  end else if (!space_held) begin
                     spacebar_pressed <= 1'b1;
                     space_held       <= 1'b1;
                  end
               end
               brk <= 1'b0;
               ext <= 1'b0;
            end
         end
      end
   end

   assign led = {space_held, led_low};

endmodule

// File: tb/tb_ps2_space_decoder.sv
// Self-checking bench for ps2_space_decoder: frame table with a pulse scoreboard,
// plus hand-written bad-start, timeout, glitch and mid-frame reset sequences.
module tb_ps2_space_decoder;

   localparam int FILTER_LEN = 8;
   localparam int TMO        = 2000;
   localparam int HALF       = 40;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2c;
   logic       ps2d;
   logic       spacebar_pressed;
   logic       space_held;
   logic [7:0] led;
   logic       frame_err;

   ps2_space_decoder #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .ps2c             (ps2c),
      .ps2d             (ps2d),
      .spacebar_pressed (spacebar_pressed),
      .space_held       (space_held),
      .led              (led),
      .frame_err        (frame_err)
   );

   always #10 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_NONE, EV_PRESS, EV_ERR, EV_TMO} ev_e;

   typedef struct {
      ev_e         kind;
      int unsigned lo;
      int unsigned hi;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       par_flip;
      logic       stop_b;
      ev_e        ev;
      logic       held;
      logic [7:0] led;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[20];

   int n_checks = 0;
   int n_errors = 0;
   int n_press  = 0;
   int n_ferr   = 0;
   logic prev_press = 1'b0;
   logic prev_err   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_pop(input ev_e k, input string name);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_unexpected: got pulse at cycle %0d, expected none", name, cyc);
      end else begin
         e = sb.pop_front();
         check({name, "_kind"}, 32'(int'(k)), 32'(int'(e.kind)));
         n_checks++;
         if (cyc < e.lo || cyc > e.hi) begin
            n_errors++;
            $display("FAIL %s_time: got cycle %0d, expected %0d..%0d", name, cyc, e.lo, e.hi);
         end
      end
   endtask

   // Pulse monitor: every strobe must match the next expected event in time.
   always @(negedge clk) begin
      if (prev_press) check("press_width", 32'(spacebar_pressed), 32'd0);
      if (prev_err)   check("err_width", 32'(frame_err), 32'd0);
      if (spacebar_pressed === 1'b1) begin
         n_press++;
         sb_pop(EV_PRESS, "press");
      end
      if (frame_err === 1'b1) begin
         n_ferr++;
         sb_pop(EV_ERR, "frame_err");
      end
      prev_press <= (spacebar_pressed === 1'b1);
      prev_err   <= (frame_err === 1'b1);
   end

   // Raw ps2c fall at cycle c: filtered fall is seen at c+10, so frame_err
   // is visible at c+11 and spacebar_pressed at c+12.
   task automatic push_ev(input ev_e ev, input int unsigned c);
      case (ev)
         EV_PRESS: sb.push_back('{EV_PRESS, c + 12, c + 12});
         EV_ERR:   sb.push_back('{EV_ERR, c + 11, c + 11});
         EV_TMO:   sb.push_back('{EV_ERR, c + TMO + 9, c + TMO + 13});
         default: ;
      endcase
   endtask

   task automatic send_bit(input logic b, input ev_e ev);
      ps2d = b;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      push_ev(ev, cyc);
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b,
                             input ev_e ev);
      send_bit(1'b0, EV_NONE);
      for (int i = 0; i < 8; i++) send_bit(d[i], EV_NONE);
      send_bit((~^d) ^ par_flip, EV_NONE);
      send_bit(stop_b, ev);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      int e0;

      vecs[0]  = '{8'h29, 1'b0, 1'b1, EV_PRESS, 1'b1, 8'hA9};
      vecs[1]  = '{8'h29, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hA9};
      vecs[2]  = '{8'h29, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hA9};
      vecs[3]  = '{8'h29, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hA9};
      vecs[4]  = '{8'hF0, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hF0};
      vecs[5]  = '{8'h29, 1'b0, 1'b1, EV_NONE,  1'b0, 8'h29};
      vecs[6]  = '{8'h29, 1'b1, 1'b1, EV_ERR,   1'b0, 8'h29};
      vecs[7]  = '{8'h29, 1'b0, 1'b1, EV_PRESS, 1'b1, 8'hA9};
      vecs[8]  = '{8'hF0, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hF0};
      vecs[9]  = '{8'h29, 1'b0, 1'b1, EV_NONE,  1'b0, 8'h29};
      vecs[10] = '{8'hE0, 1'b0, 1'b1, EV_NONE,  1'b0, 8'h60};
      vecs[11] = '{8'h29, 1'b0, 1'b1, EV_NONE,  1'b0, 8'h29};
      vecs[12] = '{8'h1C, 1'b0, 1'b1, EV_NONE,  1'b0, 8'h1C};
      vecs[13] = '{8'h29, 1'b0, 1'b0, EV_ERR,   1'b0, 8'h1C};
      vecs[14] = '{8'h29, 1'b0, 1'b1, EV_PRESS, 1'b1, 8'hA9};
      vecs[15] = '{8'hE0, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hE0};
      vecs[16] = '{8'hF0, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hF0};
      vecs[17] = '{8'h29, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hA9};
      vecs[18] = '{8'hF0, 1'b0, 1'b1, EV_NONE,  1'b1, 8'hF0};
      vecs[19] = '{8'h29, 1'b0, 1'b1, EV_NONE,  1'b0, 8'h29};

      rst  = 1'b1;
      ps2c = 1'b1;
      ps2d = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_press", 32'(spacebar_pressed), 32'd0);
      check("rst_held",  32'(space_held), 32'd0);
      check("rst_led",   32'(led), 32'h00);
      check("rst_err",   32'(frame_err), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Back-to-back frames straight from the table.
      for (int i = 0; i < 20; i++) begin
         send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop_b, vecs[i].ev);
         check($sformatf("v%0d_held", i), 32'(space_held), 32'(vecs[i].held));
         check($sformatf("v%0d_led", i),  32'(led), 32'(vecs[i].led));
      end
      check("table_presses", 32'(n_press), 32'd3);
      check("table_errs",    32'(n_ferr), 32'd2);

      // Start bit of 1 while idle.
      send_bit(1'b1, EV_ERR);
      repeat (20) @(negedge clk);
      check("bad_start_err", 32'(n_ferr), 32'd3);

      // Start plus four data bits, then silence until the watchdog fires.
      send_bit(1'b0, EV_NONE);
      send_bit(1'b1, EV_NONE);
      send_bit(1'b0, EV_NONE);
      send_bit(1'b0, EV_NONE);
      send_bit(1'b1, EV_TMO);
      repeat (TMO + 50) @(negedge clk);
      check("timeout_err", 32'(n_ferr), 32'd4);
      send_frame(8'h29, 1'b0, 1'b1, EV_PRESS);
      check("post_tmo_press", 32'(n_press), 32'd4);
      check("post_tmo_held",  32'(space_held), 32'd1);
      check("post_tmo_led",   32'(led), 32'hA9);

      // Short low glitch on ps2c must not produce a filtered fall.
      p0 = n_press;
      e0 = n_ferr;
      ps2c = 1'b0;
      repeat (5) @(negedge clk);
      ps2c = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_err",   32'(n_ferr), 32'(e0));
      check("glitch_press", 32'(n_press), 32'(p0));

      // Reset after start + three data bits of 0x29, during a high phase.
      send_bit(1'b0, EV_NONE);
      send_bit(1'b1, EV_NONE);
      send_bit(1'b0, EV_NONE);
      send_bit(1'b0, EV_NONE);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_press", 32'(spacebar_pressed), 32'd0);
      check("mid_rst_held",  32'(space_held), 32'd0);
      check("mid_rst_led",   32'(led), 32'h00);
      check("mid_rst_err",   32'(frame_err), 32'd0);
      rst = 1'b0;
      // Remaining bits 1,0,1,0,0, parity 0, stop 1: a bad start, then a
      // five-bit partial frame that can only end in a timeout.
      send_bit(1'b1, EV_ERR);
      send_bit(1'b0, EV_NONE);
      send_bit(1'b1, EV_NONE);
      send_bit(1'b0, EV_NONE);
      send_bit(1'b0, EV_NONE);
      send_bit(1'b0, EV_NONE);
      send_bit(1'b1, EV_TMO);
      repeat (TMO + 50) @(negedge clk);
      check("tail_press", 32'(n_press), 32'd4);
      check("tail_held",  32'(space_held), 32'd0);
      check("tail_led",   32'(led), 32'h00);
      check("tail_errs",  32'(n_ferr), 32'd6);
      check("sb_drain",   32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
